// File: rtl/mult_accum_pkg.sv
// rtl/mult_accum_pkg.sv - shared state encoding and constants for mult_accum_4bit
// Contents: state_t (ACCUM/DONE), default parameter values, largest 4x4 product.
package mult_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int N_TERMS_DEF = 4;
    localparam int ACC_W_DEF   = 12;
    localparam int PROD_MAX    = 225;

endpackage

// File: rtl/Wallace_Mult_4bit.sv
// rtl/Wallace_Mult_4bit.sv - combinational 4x4 unsigned Wallace-tree multiplier
// Ports: a, b (4-bit unsigned operands) -> p (8-bit product).
module Wallace_Mult_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // {carry, sum} of a half adder and a full adder
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {1'b0, x} + {1'b0, y} + {1'b0, z};
    endfunction

    // pp[i][j] = b[i] & a[j], weight i+j
    logic [3:0][3:0] pp;
    always_comb begin
        pp = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = b[i] & a[j];
            end
        end
    end

    // First layer: reduces column heights 1,2,3,4,3,2,1
    logic s1_1, c1_1, s1_2, c1_2, s1_3, c1_3, s1_4, c1_4, s1_5, c1_5;
    assign {c1_1, s1_1} = ha(pp[0][1], pp[1][0]);
    assign {c1_2, s1_2} = fa(pp[0][2], pp[1][1], pp[2][0]);
    assign {c1_3, s1_3} = fa(pp[0][3], pp[1][2], pp[2][1]);
    assign {c1_4, s1_4} = fa(pp[1][3], pp[2][2], pp[3][1]);
    assign {c1_5, s1_5} = ha(pp[2][3], pp[3][2]);

    // Second layer: brings every column down to at most two bits
    logic s2_3, c2_3, s2_4, c2_4, s2_5, c2_5, s2_6, c2_6;
    assign {c2_3, s2_3} = fa(c1_2, s1_3, pp[3][0]);
    assign {c2_4, s2_4} = ha(c1_3, s1_4);
    assign {c2_5, s2_5} = ha(c1_4, s1_5);
    assign {c2_6, s2_6} = ha(c1_5, pp[3][3]);

    // Final carry-propagate add of the two remaining rows
    logic [7:0] row_x, row_y;
    assign row_x = {c2_6, s2_6, s2_5, s2_4, s2_3, s1_2, s1_1, pp[0][0]};
    assign row_y = {1'b0, c2_5, c2_4, c2_3, 1'b0, c1_1, 2'b00};
    assign p     = row_x + row_y;

endmodule

// File: rtl/mult_accum_4bit.sv
// rtl/mult_accum_4bit.sv - accumulates N_TERMS products a*b and hands the sum over with valid/ready
// Ports: clk; rst (sync, active-high); clr (sync abort of current accumulation);
//        a, b, in_valid -> in_ready (operand input); acc, ovf, out_valid <- out_ready (result).
// Build option: MULT_ACCUM_SATURATE_EN clamps acc at 2^ACC_W-1 on overflow; otherwise acc wraps.
module mult_accum_4bit
    import mult_accum_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int               CNT_W    = $clog2(N_TERMS + 1);
    localparam int               PROD_W   = $clog2(PROD_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    sum;
    logic              sum_ovf;
    logic [ACC_W-1:0]  next_acc;

    Wallace_Mult_4bit u_mult (
        .a (a),
        .b (b),
        .p (prod)
    );

    // Handshake flags are straight decodes of the state flop
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);

    // One extra bit catches the carry out of the accumulator
    assign sum     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign sum_ovf = sum[ACC_W];

`ifdef MULT_ACCUM_SATURATE_EN
    // Once clamped, any non-zero product overflows again, so acc stays pinned
    assign next_acc = sum_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign next_acc = sum[ACC_W-1:0];
`endif

    // rst and clr have the same effect and both override any handshake
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= next_acc;
                        ovf <= ovf | sum_ovf;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // in_valid is ignored here, giving a one-cycle bubble on exit
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accum_4bit.sv
// tb/tb_mult_accum_4bit.sv - self-checking bench for mult_accum_4bit (default, N_TERMS=2/ACC_W=8, N_TERMS=1)
module tb_mult_accum_4bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr;
    logic [3:0] a, b;
    logic       iv0, iv1, iv2, or0, or1, or2;
    logic       ir0, ir1, ir2, ov0, ov1, ov2, f0, f1, f2;
    logic [11:0] acc0, acc2;
    logic [7:0]  acc1;

    mult_accum_4bit dut0 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b),
        .in_valid(iv0), .in_ready(ir0), .acc(acc0), .ovf(f0),
        .out_valid(ov0), .out_ready(or0)
    );

    mult_accum_4bit #(.N_TERMS(2), .ACC_W(8)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b),
        .in_valid(iv1), .in_ready(ir1), .acc(acc1), .ovf(f1),
        .out_valid(ov1), .out_ready(or1)
    );

    mult_accum_4bit #(.N_TERMS(1)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .a(a), .b(b),
        .in_valid(iv2), .in_ready(ir2), .acc(acc2), .ovf(f2),
        .out_valid(ov2), .out_ready(or2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int pa[4];
        int pb[4];
        int exp_acc;
        int exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result is the plain sum of all products, then wrapped or clamped
    function automatic longint model_acc(input longint total, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
`ifdef MULT_ACCUM_SATURATE_EN
        return (total > mx) ? mx : total;
`else
        return total & mx;
`endif
    endfunction

    function automatic logic model_ovf(input longint total, input int w);
        return total > ((longint'(1) << w) - 1);
    endfunction

    function automatic logic [31:0] get_acc(input int which);
        return (which == 0) ? 32'(acc0) : 32'(acc1);
    endfunction

    function automatic logic get_ovf(input int which);
        return (which == 0) ? f0 : f1;
    endfunction

    function automatic logic get_ov(input int which);
        return (which == 0) ? ov0 : ov1;
    endfunction

    function automatic logic get_ir(input int which);
        return (which == 0) ? ir0 : ir1;
    endfunction

    task automatic set_iv(input int which, input logic v);
        if (which == 0) iv0 = v; else iv1 = v;
    endtask

    task automatic set_or(input int which, input logic v);
        if (which == 0) or0 = v; else or1 = v;
    endtask

    // Push n back-to-back pairs into dut0 (same pair each time)
    task automatic push0(input int n, input logic [3:0] pa, input logic [3:0] pb);
        a = pa; b = pb; iv0 = 1'b1;
        repeat (n) tick();
        iv0 = 1'b0;
    endtask

    task automatic consume0();
        or0 = 1'b1;
        tick();
        or0 = 1'b0;
    endtask

    task automatic run_rand(input int which, input int n_res);
        int nt, w;
        longint total;
        nt = (which == 0) ? 4 : 2;
        w  = (which == 0) ? 12 : 8;
        for (int r = 0; r < n_res; r++) begin
            total = 0;
            for (int k = 0; k < nt; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    chk("rand idle acc", get_acc(which), 32'(model_acc(total, w)));
                end
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                set_iv(which, 1'b1);
                tick();
                set_iv(which, 1'b0);
                total += longint'(a) * longint'(b);
                chk("rand acc", get_acc(which), 32'(model_acc(total, w)));
                chk("rand ovf", 32'(get_ovf(which)), 32'(model_ovf(total, w)));
                chk("rand out_valid", 32'(get_ov(which)), 32'(k == nt - 1));
            end
            repeat ($urandom_range(0, 3)) tick();
            chk("rand hold acc", get_acc(which), 32'(model_acc(total, w)));
            chk("rand hold valid", 32'(get_ov(which)), 32'd1);
            set_or(which, 1'b1);
            tick();
            set_or(which, 1'b0);
            chk("rand consumed acc", get_acc(which), 32'd0);
            chk("rand consumed ovf", 32'(get_ovf(which)), 32'd0);
            chk("rand consumed ready", 32'(get_ir(which)), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; a = '0; b = '0;
        iv0 = 0; iv1 = 0; iv2 = 0; or0 = 0; or1 = 0; or2 = 0;

        vecs[0].pa = '{3, 15, 0, 7};    vecs[0].pb = '{5, 15, 9, 2};    vecs[0].exp_acc = 254; vecs[0].exp_ovf = 0;
        vecs[1].pa = '{15, 15, 15, 15}; vecs[1].pb = '{15, 15, 15, 15}; vecs[1].exp_acc = 900; vecs[1].exp_ovf = 0;
        vecs[2].pa = '{1, 2, 3, 4};     vecs[2].pb = '{1, 2, 3, 4};     vecs[2].exp_acc = 30;  vecs[2].exp_ovf = 0;
        vecs[3].pa = '{8, 10, 12, 14};  vecs[3].pb = '{9, 11, 13, 15};  vecs[3].exp_acc = 548; vecs[3].exp_ovf = 0;
        vecs[4].pa = '{0, 0, 0, 0};     vecs[4].pb = '{0, 0, 0, 0};     vecs[4].exp_acc = 0;   vecs[4].exp_ovf = 0;

        tick(); tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(ir0), 32'd1);
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset acc", 32'(acc0), 32'd0);
        chk("reset ovf", 32'(f0), 32'd0);
        chk("reset in_ready n2", 32'(ir1), 32'd1);
        chk("reset in_ready n1", 32'(ir2), 32'd1);

        // Table-driven results on the default configuration
        for (int i = 0; i < 5; i++) begin
            iv0 = 1'b1;
            for (int k = 0; k < 4; k++) begin
                a = 4'(vecs[i].pa[k]);
                b = 4'(vecs[i].pb[k]);
                tick();
                if (k < 3) chk("vec early out_valid", 32'(ov0), 32'd0);
            end
            iv0 = 1'b0;
            chk("vec out_valid", 32'(ov0), 32'd1);
            chk("vec in_ready", 32'(ir0), 32'd0);
            chk("vec acc", 32'(acc0), 32'(vecs[i].exp_acc));
            chk("vec ovf", 32'(f0), 32'(vecs[i].exp_ovf));
            consume0();
            chk("vec consumed acc", 32'(acc0), 32'd0);
            chk("vec consumed ready", 32'(ir0), 32'd1);
        end

        // Back-pressure: result held, extra pairs ignored, bubble on exit
        iv0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 4'(vecs[0].pa[k]); b = 4'(vecs[0].pb[k]);
            tick();
        end
        a = 4'd15; b = 4'd15;
        repeat (3) begin
            tick();
            chk("stall acc", 32'(acc0), 32'd254);
            chk("stall in_ready", 32'(ir0), 32'd0);
            chk("stall out_valid", 32'(ov0), 32'd1);
        end
        or0 = 1'b1;
        tick();
        or0 = 1'b0; iv0 = 1'b0;
        chk("release acc", 32'(acc0), 32'd0);
        chk("release in_ready", 32'(ir0), 32'd1);
        tick();
        chk("bubble pair dropped", 32'(acc0), 32'd0);

        // clr mid-accumulation with a simultaneous pair
        a = 4'd15; b = 4'd15; iv0 = 1'b1; tick();
        a = 4'd3;  b = 4'd5;  tick();
        iv0 = 1'b0;
        chk("pre-clr acc", 32'(acc0), 32'd240);
        a = 4'd4; b = 4'd4; iv0 = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0; iv0 = 1'b0;
        chk("clr acc", 32'(acc0), 32'd0);
        chk("clr in_ready", 32'(ir0), 32'd1);
        push0(3, 4'd1, 4'd1);
        chk("post-clr count", 32'(ov0), 32'd0);
        push0(1, 4'd1, 4'd1);
        chk("post-clr done", 32'(ov0), 32'd1);
        chk("post-clr acc", 32'(acc0), 32'd4);

        // clr in DONE discards the result
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr done out_valid", 32'(ov0), 32'd0);
        chk("clr done acc", 32'(acc0), 32'd0);

        // rst in DONE beats handshake and a new pair
        push0(4, 4'd9, 4'd7);
        chk("pre-rst acc", 32'(acc0), 32'd252);
        rst = 1'b1; or0 = 1'b1; iv0 = 1'b1; a = 4'd5; b = 4'd5;
        tick();
        rst = 1'b0; or0 = 1'b0; iv0 = 1'b0;
        chk("rst done acc", 32'(acc0), 32'd0);
        chk("rst done ovf", 32'(f0), 32'd0);
        chk("rst done out_valid", 32'(ov0), 32'd0);
        chk("rst done in_ready", 32'(ir0), 32'd1);

        // rst mid-accumulation beats clr and a pair; counter restarts
        push0(2, 4'd2, 4'd2);
        rst = 1'b1; clr = 1'b1; iv0 = 1'b1;
        tick();
        rst = 1'b0; clr = 1'b0; iv0 = 1'b0;
        chk("rst mid acc", 32'(acc0), 32'd0);
        push0(3, 4'd2, 4'd3);
        chk("rst mid count", 32'(ov0), 32'd0);
        push0(1, 4'd2, 4'd3);
        chk("rst mid result", 32'(acc0), 32'd24);
        consume0();

        // Narrow accumulator overflow
        a = 4'd15; b = 4'd15; iv1 = 1'b1;
        tick(); tick();
        iv1 = 1'b0;
        chk("n2 out_valid", 32'(ov1), 32'd1);
`ifdef MULT_ACCUM_SATURATE_EN
        chk("n2 acc", 32'(acc1), 32'd255);
`else
        chk("n2 acc", 32'(acc1), 32'd194);
`endif
        chk("n2 ovf", 32'(f1), 32'd1);
        or1 = 1'b1; tick(); or1 = 1'b0;
        chk("n2 ovf cleared", 32'(f1), 32'd0);
        chk("n2 acc cleared", 32'(acc1), 32'd0);

        // Single-term configuration
        a = 4'd9; b = 4'd9; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        chk("n1 out_valid", 32'(ov2), 32'd1);
        chk("n1 acc", 32'(acc2), 32'd81);
        or2 = 1'b1; tick(); or2 = 1'b0;
        chk("n1 in_ready", 32'(ir2), 32'd1);

        run_rand(0, 25);
        run_rand(1, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_accum_4bit.md
MULT_ACCUM_4BIT -- requirements
Module: mult_accum_4bit

Interface
REQ-001 Parameter N_TERMS, default 4: number of products summed per result, legal range 1..255.
REQ-002 Parameter ACC_W, default 12: accumulator width in bits, legal range 8..32.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list, in this order:
  - clk  input  1  rising-edge clock.
  - rst  input  1  synchronous active-high reset.
  - clr  input  1  synchronous abort and restart of the current accumulation.
  - a  input  4  unsigned multiplicand.
  - b  input  4  unsigned multiplier.
  - in_valid  input  1  a/b hold a valid operand pair.
  - in_ready  output  1  block can accept an operand pair.
  - acc  output  ACC_W  accumulated sum.
  - ovf  output  1  sticky overflow flag for the current result.
  - out_valid  output  1  acc holds a completed result.
  - out_ready  input  1  consumer accepts the result.

Function
REQ-005 The block SHALL have two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-006 An operand pair is accepted when in_valid=1 and in_ready=1 on a rising edge.
REQ-007 On accept, the block SHALL form the 8-bit product a*b combinationally and register acc+product into acc at that edge.
REQ-008 On accept, the block SHALL increment cnt (width ceil(log2(N_TERMS+1))).
REQ-009 On the accept where cnt==N_TERMS-1, the block SHALL move to DONE, so out_valid is 1 on the cycle after the last accept (latency 1).
REQ-010 In DONE, acc and ovf SHALL be held stable until out_ready=1.
REQ-011 In DONE with out_ready=1, the next edge SHALL clear acc, ovf and cnt to 0 and return to ACCUM.
REQ-012 in_valid asserted on the cycle DONE is left SHALL NOT be accepted; this is a one-cycle bubble.
REQ-013 If the sum acc+product exceeds 2^ACC_W-1, ovf SHALL be set and SHALL stay set until the result is consumed, clr, or rst.
REQ-014 In ACCUM with in_valid=0, acc, cnt and ovf SHALL hold.
REQ-015 clr=1 SHALL, at the next edge, clear acc, ovf and cnt and enter ACCUM, in either state.
REQ-016 clr SHALL take priority over a simultaneous accept or result handshake; the pair is dropped and the result discarded.
REQ-017 With N_TERMS=1, every accept SHALL go directly to DONE.

Reset
REQ-018 When rst=1 at an edge, the block SHALL enter ACCUM with acc=0, ovf=0, cnt=0, out_valid=0 and in_ready=1.
REQ-019 rst SHALL take priority over clr and any handshake, including mid-accumulation and in DONE.
REQ-020 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-021 Macro MULT_ACCUM_SATURATE_EN defined: on overflow, acc SHALL clamp to 2^ACC_W-1 and further accepts leave it clamped.
REQ-022 Macro MULT_ACCUM_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W.
REQ-023 ovf SHALL behave identically with and without MULT_ACCUM_SATURATE_EN.

Structure
REQ-024 Shared package mult_accum_pkg SHALL hold:
  - the state encoding (ACCUM=1'b0, DONE=1'b1);
  - the defaults N_TERMS_DEF=4 and ACC_W_DEF=12;
  - the constant PROD_MAX=225.
REQ-025 The product SHALL come from one instance of the existing combinational 4-bit Wallace multiplier sub-module, Wallace_Mult_4bit; the top level contains the FSM, counter, adder and clamp only.

Verification
REQ-026 Defaults, pairs (3,5),(15,15),(0,9),(7,2) on consecutive cycles -> out_valid=1 on the cycle after the 4th accept, acc=254, ovf=0.
REQ-027 ACC_W=8, N_TERMS=2, pairs (15,15),(15,15) -> without MULT_ACCUM_SATURATE_EN acc=194, ovf=1; with it acc=255, ovf=1.
REQ-028 Result ready, out_ready held 0 for 3 cycles -> acc stays 254, in_ready=0, extra in_valid ignored; then out_ready=1 -> next cycle acc=0, in_ready=1.
REQ-029 Two accepts (acc=240), then clr together with in_valid (4,4) -> next cycle acc=0, cnt=0, pair dropped; 4 new pairs (1,1) give acc=4.
REQ-030 rst asserted in DONE with out_ready=1 and in_valid=1 -> next cycle acc=0, ovf=0, out_valid=0, in_ready=1.
REQ-031 N_TERMS=1, pair (9,9) -> out_valid=1 the next cycle with acc=81.
